debug_tx_sequencer: RTL and testbench
=====================================

// Module: debug_tx_sequencer
// PURPOSE
//   Serialises the N-bit debug snapshot (PC, instruction, control signals, register file, hazard signals) into bytes for the UART transmitter.
//   Sits between the debug snapshot packer and uart_tx.
//   On a send request it freezes a copy of the snapshot, then sends it byte 0 first (bits [7:0]) through the UART start/done handshake.
//   It signals completion once the last byte has been sent.
// PARAMETERS
//   N       1184  snapshot width in bits; must be a multiple of 8
//   NBYTES  N/8   bytes per frame (148 at default); localparam, derived from N
//   IW      8     byte-index counter width; must satisfy 2**IW > NBYTES
// PORTS
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous, active-high
//   send_req      in   1  start-frame request, sampled in IDLE only
//   buffer_envio  in   N  live snapshot from the packer
//   tx_done_tick  in   1  1-cycle pulse from uart_tx: current byte finished
//   tx_start      out  1  1-cycle pulse: uart_tx loads tx_data
//   tx_data       out  8  byte to send
//   busy          out  1  high from the cycle after send_req is accepted until done_tick
//   done_tick     out  1  1-cycle pulse after the final byte's tx_done_tick
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values: tx_start=0, tx_data=8'h00, busy=0, done_tick=0, state=IDLE, idx=0, snapshot=0.
//   - States: IDLE -> LOAD -> WAIT -> (LOAD | DONE) -> IDLE.
//   - IDLE: on an edge where send_req=1, do all of the following at that edge:
//     - snapshot<=buffer_envio, idx<=0, busy<=1;
//     - go to LOAD.
//   - LOAD (one cycle): at its closing edge:
//     - tx_data<=snapshot[8*idx+:8], tx_start<=1;
//     - go to WAIT.
//     - tx_start is therefore high exactly during the first WAIT cycle.
//   - WAIT: tx_start<=0 after one cycle; tx_data is held stable until the next LOAD.
//   - WAIT, on tx_done_tick=1:
//     - if idx==LAST, go to DONE;
//     - otherwise idx<=idx+1 and go to LOAD.
//     - LAST=NBYTES-1, or NBYTES when CHECKSUM_EN is defined.
//   - DONE (one cycle): done_tick<=1 and busy<=0; then IDLE.
//   - Latency:
//     - send_req sampled at edge k -> tx_start high in cycle k+2.
//     - tx_done_tick sampled at edge m -> next tx_start high in cycle m+2.
//     - Last tx_done_tick at edge m -> done_tick high in cycle m+2.
//   - The snapshot is frozen for the whole frame; later buffer_envio changes do not affect the bytes sent.
//   - send_req is ignored outside IDLE (no queuing).
//   - send_req held high continuously: a new frame starts on the first IDLE cycle after DONE.
//   - tx_done_tick outside WAIT is ignored, including in the LOAD cycle and in IDLE.
//   - Reset mid-frame: the next cycle is IDLE with reset values; no done_tick; the partial frame is abandoned.
//   - Index wrap-around cannot occur, because idx never exceeds LAST.
// CONFIGURATION
//   CHECKSUM_EN defined:
//   - one extra byte follows byte NBYTES-1: the XOR of all NBYTES snapshot bytes;
//   - it is accumulated while loading bytes and cleared on frame start;
//   - frame length is NBYTES+1.
//   CHECKSUM_EN undefined:
//   - frame is exactly NBYTES bytes;
//   - no checksum register is built.
// TESTING
//   1. Hold reset 3 cycles -> tx_start=0, busy=0, done_tick=0, tx_data=00 in every cycle.
//   2. buffer byte i = i[7:0]; send_req pulse; bench answers each tx_start with tx_done_tick 3 cycles later
//      -> 148 tx_start pulses, tx_data 00..93 in order, one done_tick, then busy=0.
//   3. During test 2, pulse send_req at byte 10 and flip buffer_envio to all 1s
//      -> still 148 bytes, all values from the original snapshot.
//   4. reset at byte 50 -> IDLE next cycle, no done_tick; new send_req -> first tx_data=00, 148 bytes sent.
//   5. tx_done_tick pulses in IDLE and in the LOAD cycle -> no tx_start, idx unchanged.
//   6. CHECKSUM_EN: byte0=5A, byte147=0F, all others 00 -> 149 bytes, last tx_data=55.

Source files
------------

// File: rtl/debug_tx_sequencer.sv
// Serialises the frozen N-bit debug snapshot into UART bytes, byte 0 (bits [7:0]) first.
// Optional build macro CHECKSUM_EN appends one XOR checksum byte after the last snapshot byte.
module debug_tx_sequencer #(
  parameter int N  = 1184,
  parameter int IW = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         send_req,
  input  logic [N-1:0] buffer_envio,
  input  logic         tx_done_tick,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         busy,
  output logic         done_tick
);

  localparam int NBYTES = N / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

`ifdef CHECKSUM_EN
  // The checksum byte occupies index NBYTES, one past the snapshot.
  localparam logic [IW-1:0] LAST = IW'(NBYTES);
  logic [7:0] csum_r;
`else
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
`endif

  logic [1:0]    state_r;
  logic [IW-1:0] idx_r;
  logic [N-1:0]  snapshot_r;
  logic          tx_start_r;
  logic [7:0]    tx_data_r;
  logic          busy_r;
  logic          done_tick_r;
  logic [7:0]    byte_s;

  // Select the byte for the current index from the frozen snapshot (or the checksum).
  always_comb begin
    byte_s = 8'h00;
`ifdef CHECKSUM_EN
    if (idx_r == LAST) begin
      byte_s = csum_r;
    end else begin
      byte_s = snapshot_r[{idx_r, 3'b000} +: 8];
    end
`else
    byte_s = snapshot_r[{idx_r, 3'b000} +: 8];
`endif
  end

  // Frame sequencer: freeze snapshot, step through bytes with the UART handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      snapshot_r  <= {N{1'b0}};
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      busy_r      <= 1'b0;
      done_tick_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tx_start_r  <= 1'b0;
          done_tick_r <= 1'b0;
          if (send_req) begin
            snapshot_r <= buffer_envio;
            idx_r      <= {IW{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= LOAD;
          end
        end
        LOAD: begin
          tx_data_r  <= byte_s;
          tx_start_r <= 1'b1;
          state_r    <= WAIT;
        end
        WAIT: begin
          tx_start_r <= 1'b0;
          if (tx_done_tick) begin
            if (idx_r == LAST) begin
              state_r <= DONE;
            end else begin
              idx_r   <= idx_r + IW'(1);
              state_r <= LOAD;
            end
          end
        end
        DONE: begin
          done_tick_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          tx_start_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHECKSUM_EN
  // XOR accumulator over snapshot bytes as they are loaded; cleared on frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_r <= 8'h00;
    end else if (state_r == IDLE && send_req) begin
      csum_r <= 8'h00;
    end else if (state_r == LOAD && idx_r != LAST) begin
      csum_r <= csum_r ^ byte_s;
    end
  end
`endif

  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign busy      = busy_r;
  assign done_tick = done_tick_r;

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Directed self-checking bench for debug_tx_sequencer; acts as the uart_tx side,
// answering each tx_start with a tx_done_tick three cycles later.
module tb_debug_tx_sequencer;

  localparam int N  = 1184;
  localparam int NB = N / 8;
`ifdef CHECKSUM_EN
  localparam int FRAME = NB + 1;
`else
  localparam int FRAME = NB;
`endif

  logic         clk;
  logic         reset;
  logic         send_req;
  logic [N-1:0] buffer_envio;
  logic         tx_done_tick;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         busy;
  logic         done_tick;

  int n_cmp;
  int n_err;

  logic [N-1:0] pat_inc;
  logic [N-1:0] pat_sparse;

  debug_tx_sequencer #(.N(N), .IW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .send_req     (send_req),
    .buffer_envio (buffer_envio),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .done_tick    (done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [N-1:0] snap, input int b);
    logic [7:0] x;
    x = 8'h00;
    if (b < NB) begin
      x = snap[8*b +: 8];
    end else begin
      for (int i = 0; i < NB; i++) x = x ^ snap[8*i +: 8];
    end
    return x;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_tx_start"},  32'(tx_start),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done_tick"}, 32'(done_tick), 32'd0);
  endtask

  // One frame: request, then answer every byte; optional disturbance, abort and LOAD-cycle glitch.
  task automatic run_frame(input logic [N-1:0] snap, input int disturb_at,
                           input int abort_at, input bit load_glitch);
    int nsent;
    nsent = 0;
    buffer_envio = snap;
    send_req = 1'b1;
    tick;
    send_req = 1'b0;
    check("busy_after_req", 32'(busy), 32'd1);
    check("tx_start_in_load", 32'(tx_start), 32'd0);
    if (load_glitch) tx_done_tick = 1'b1;
    tick;
    tx_done_tick = 1'b0;
    for (int b = 0; b < FRAME; b++) begin
      check("tx_start_pulse", 32'(tx_start), 32'd1);
      check("tx_data", 32'(tx_data), 32'(exp_byte(snap, b)));
      check("busy_in_frame", 32'(busy), 32'd1);
      if (tx_start) nsent++;
      if (b == abort_at) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_quiet("abort");
        check("abort_tx_data", 32'(tx_data), 32'h00);
        for (int i = 0; i < 6; i++) begin
          tick;
          check_quiet("after_abort");
        end
        return;
      end
      tick;
      check("tx_start_drop", 32'(tx_start), 32'd0);
      if (b == disturb_at) begin
        send_req = 1'b1;
        buffer_envio = {N{1'b1}};
      end
      tick;
      send_req = 1'b0;
      check("tx_data_hold", 32'(tx_data), 32'(exp_byte(snap, b)));
      tick;
      tx_done_tick = 1'b1;
      tick;
      tx_done_tick = 1'b0;
      check("no_early_done", 32'(done_tick), 32'd0);
      tick;
    end
    check("frame_len", 32'(nsent), 32'(FRAME));
    check("done_tick_high", 32'(done_tick), 32'd1);
    check("busy_clear", 32'(busy), 32'd0);
    check("last_tx_data", 32'(tx_data), 32'(exp_byte(snap, FRAME - 1)));
    tick;
    check_quiet("after_done");
    tick;
    check_quiet("idle_settled");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    send_req = 1'b0;
    tx_done_tick = 1'b0;
    buffer_envio = {N{1'b0}};
    for (int i = 0; i < NB; i++) pat_inc[8*i +: 8] = 8'(i);
    pat_sparse = {N{1'b0}};
    pat_sparse[7:0] = 8'h5A;
    pat_sparse[N-1 -: 8] = 8'h0F;

    // Reset held three cycles, with a request pending that must be ignored.
    send_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_quiet("reset");
      check("reset_tx_data", 32'(tx_data), 32'h00);
    end
    send_req = 1'b0;
    reset = 1'b0;
    tick;
    check_quiet("post_reset");

    // Incrementing bytes, plain frame.
    run_frame(pat_inc, -1, -1, 1'b0);

    // Request and buffer change mid-frame are ignored.
    run_frame(pat_inc, 10, -1, 1'b0);

    // Abort with reset at byte 50, then a complete fresh frame.
    run_frame(pat_inc, -1, 50, 1'b0);
    run_frame(pat_inc, -1, -1, 1'b0);

    // Stray tx_done_tick in IDLE, then one in the LOAD cycle.
    tx_done_tick = 1'b1;
    tick;
    tx_done_tick = 1'b0;
    check_quiet("idle_glitch");
    tick;
    check_quiet("idle_glitch2");
    run_frame(pat_inc, -1, -1, 1'b1);

    // Sparse pattern; with CHECKSUM_EN the trailing byte is 5A^0F = 55.
    run_frame(pat_sparse, -1, -1, 1'b0);
`ifdef CHECKSUM_EN
    check("checksum_byte", 32'(tx_data), 32'h55);
`else
    check("last_byte_0f", 32'(tx_data), 32'h0F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
